// File: rtl/lfsr_prbs_lock_check.sv
// Receive-side PRBS checker: self-synchronising Fibonacci LFSR with a lock/unlock FSM,
// per-bit error mask and a saturating bit-error counter.
module lfsr_prbs_lock_check #(
  parameter int                    LFSR_WIDTH  = 31,
  parameter logic [LFSR_WIDTH-1:0] LFSR_POLY   = 31'h10000001,
  parameter logic [LFSR_WIDTH-1:0] LFSR_INIT   = {LFSR_WIDTH{1'b1}},
  parameter bit                    REVERSE     = 1'b0,
  parameter bit                    INVERT      = 1'b1,
  parameter int                    DATA_WIDTH  = 8,
  parameter int                    LOCK_COUNT  = 4,
  parameter int                    WINDOW      = 64,
  parameter int                    UNLOCK_ERRS = 8,
  parameter int                    CNT_WIDTH   = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  data_valid,
  input  logic                  err_clear,
  output logic                  locked,
  output logic [DATA_WIDTH-1:0] error_out,
  output logic                  error_valid,
  output logic [CNT_WIDTH-1:0]  bit_err_count
);

  localparam int HC_W = $clog2(LOCK_COUNT + 1);
  localparam int WC_W = $clog2(WINDOW + 1);
  localparam int EC_W = $clog2(UNLOCK_ERRS + 1);
  localparam int PW   = $clog2(DATA_WIDTH + 1);
  localparam int SW   = CNT_WIDTH + PW;
  localparam logic [SW-1:0] CNT_MAX = {{PW{1'b0}}, {CNT_WIDTH{1'b1}}};

  // Poly bit i is the x^i term; with state[0] the newest bit it taps state[W-1-i].
  function automatic logic [LFSR_WIDTH-1:0] poly_taps(input logic [LFSR_WIDTH-1:0] p);
    logic [LFSR_WIDTH-1:0] r;
    for (int i = 0; i < LFSR_WIDTH; i++) r[LFSR_WIDTH-1-i] = p[i];
    return r;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] bitrev(input logic [DATA_WIDTH-1:0] d);
    logic [DATA_WIDTH-1:0] r;
    for (int i = 0; i < DATA_WIDTH; i++) r[i] = d[DATA_WIDTH-1-i];
    return r;
  endfunction

  localparam logic [LFSR_WIDTH-1:0] TAPS = poly_taps(LFSR_POLY);

  typedef enum logic {ST_HUNT, ST_LOCK} st_t;

  st_t                   st, st_nxt;
  logic [LFSR_WIDTH-1:0] state_reg, state_nxt;
  logic [HC_W-1:0]       hunt_cnt, hunt_nxt, hunt_inc;
  logic [WC_W-1:0]       win_cnt, win_nxt, win_inc;
  logic [EC_W-1:0]       ew_cnt, ew_nxt, ew_inc;

  // Time-ordered vectors: bit DATA_WIDTH-1 is the oldest bit of the word, bit 0 the newest.
  logic [DATA_WIDTH-1:0] exp_t, rx_t, shift_t;
  logic [DATA_WIDTH-1:0] rx, exp_w, err;
  logic                  err_any;
  logic [LFSR_WIDTH-1:0] s;
  logic                  fb;

  always_comb begin
    s     = state_reg;
    fb    = 1'b0;
    exp_t = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      fb                   = ^(s & TAPS);
      exp_t[DATA_WIDTH-1-i] = fb;
      s                    = {s[LFSR_WIDTH-2:0], fb};
    end
  end

  assign rx      = INVERT ? ~data_in : data_in;
  assign rx_t    = REVERSE ? bitrev(rx) : rx;
  assign exp_w   = REVERSE ? bitrev(exp_t) : exp_t;
  assign err     = exp_w ^ rx;
  assign err_any = |err;

  // Hunting reloads from the line; locked free-runs on its own prediction.
  assign shift_t = (st == ST_HUNT) ? rx_t : exp_t;

  generate
    if (DATA_WIDTH < LFSR_WIDTH) begin : g_shift
      assign state_nxt = {state_reg[LFSR_WIDTH-DATA_WIDTH-1:0], shift_t};
    end else begin : g_load
      assign state_nxt = shift_t[LFSR_WIDTH-1:0];
    end
  endgenerate

  assign hunt_inc = hunt_cnt + HC_W'(1);
  assign win_inc  = win_cnt + WC_W'(1);
  assign ew_inc   = ew_cnt + EC_W'(err_any);

  always_ff @(posedge clk) begin
    if (rst) begin
      st       <= ST_HUNT;
      hunt_cnt <= '0;
      win_cnt  <= '0;
      ew_cnt   <= '0;
    end else begin
      st       <= st_nxt;
      hunt_cnt <= hunt_nxt;
      win_cnt  <= win_nxt;
      ew_cnt   <= ew_nxt;
    end
  end

  always_comb begin
    st_nxt   = st;
    hunt_nxt = hunt_cnt;
    win_nxt  = win_cnt;
    ew_nxt   = ew_cnt;
    if (data_valid) begin
      case (st)
        ST_HUNT: begin
          if (err_any) begin
            hunt_nxt = '0;
          end else if (hunt_inc == HC_W'(LOCK_COUNT)) begin
            st_nxt   = ST_LOCK;
            hunt_nxt = '0;
            win_nxt  = '0;
            ew_nxt   = '0;
          end else begin
            hunt_nxt = hunt_inc;
          end
        end
        ST_LOCK: begin
          // Unlock outranks window rollover on the same word.
          if (ew_inc == EC_W'(UNLOCK_ERRS)) begin
            st_nxt   = ST_HUNT;
            hunt_nxt = '0;
            win_nxt  = '0;
            ew_nxt   = '0;
          end else if (win_inc == WC_W'(WINDOW)) begin
            win_nxt = '0;
            ew_nxt  = '0;
          end else begin
            win_nxt = win_inc;
            ew_nxt  = ew_inc;
          end
        end
        default: st_nxt = ST_HUNT;
      endcase
    end
  end

  logic [PW-1:0]        pop;
  logic [SW-1:0]        sum;
  logic [CNT_WIDTH-1:0] cnt_nxt;

  always_comb begin
    pop = '0;
    for (int i = 0; i < DATA_WIDTH; i++) pop = pop + PW'(err[i]);
    sum     = SW'(bit_err_count) + SW'(pop);
    cnt_nxt = bit_err_count;
    if (err_clear)
      cnt_nxt = '0;
    else if (data_valid && st == ST_LOCK)
      cnt_nxt = (sum > CNT_MAX) ? {CNT_WIDTH{1'b1}} : sum[CNT_WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= LFSR_INIT;
      error_out     <= '0;
      error_valid   <= 1'b0;
      bit_err_count <= '0;
    end else begin
      error_valid   <= data_valid;
      bit_err_count <= cnt_nxt;
      if (data_valid) begin
        state_reg <= state_nxt;
        error_out <= err;
      end
    end
  end

  assign locked = (st == ST_LOCK);

endmodule
